move_sequencer: RTL and testbench

- Upstream stage of the grid point block. Turns player direction buttons into one signed move per turn.
- Drives the shared xMove/yMove bus and the per-player enables. Generates the update strobe that the point blocks use as their edge.
- Alternates turns between player 0 and player 1, and counts completed moves.

---
 rtl/move_sequencer.sv | 141 ++++++++++++++
 tb/tb_move_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// move_sequencer
// Turns debounced direction buttons into one signed (dx, dy) move per turn,
// presents it on xMove/yMove with the mover's enable, and fires a single
// update strobe that the point blocks treat as their clock edge. Turns
// alternate between player 0 and player 1. Completed moves are counted.
//
// Ports
//   clk, rst          system clock, async active-high reset
//   btn_up/down       +y / -y request (rising edge = press)
//   btn_right/left    +x / -x request
//   btn_go            commit the pending move
//   step_sel[1:0]     step per press (0 behaves as 1)
//   xMove, yMove[2:0] two's-complement move to the point blocks
//   update            move strobe, high for PULSE_LEN cycles
//   en0, en1          per-player point-block enable
//   turn              current player
//   move_count[7:0]   completed moves, wraps
//
// state | meaning
// IDLE  | accumulate presses; wait for go with a non-zero move
// SETUP | latch enable of the mover one cycle ahead of update
// PULSE | drive update high for PULSE_LEN cycles
// HOLD  | drop update with enable still high; finish the turn
module move_sequencer #(
   parameter int PULSE_LEN = 2,
   parameter int MAX_STEP  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_right,
   input  logic       btn_left,
   input  logic       btn_go,
   input  logic [1:0] step_sel,
   output logic [2:0] xMove,
   output logic [2:0] yMove,
   output logic       update,
   output logic       en0,
   output logic       en1,
   output logic       turn,
   output logic [7:0] move_count
);

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

   localparam logic signed [3:0] LIM = 4'(MAX_STEP);

   state_t            state;
   logic [3:0]        pulse_cnt;
   logic [4:0]        prev;
   logic [4:0]        cur;
   logic [4:0]        press;
   logic [1:0]        step;
   logic signed [2:0] dx;
   logic signed [2:0] dy;

   // bit order: up, down, right, left, go
   assign cur   = {btn_up, btn_down, btn_right, btn_left, btn_go};
   assign press = cur & ~prev;
   assign step  = (step_sel == 2'd0) ? 2'd1 : step_sel;

   assign xMove = dx;
   assign yMove = dy;

   // Sum in 4-bit signed so +3 plus a step clamps instead of wrapping to -4.
   // Opposite presses in the same cycle cancel out.
   function automatic logic signed [2:0] sat_add(input logic signed [2:0] cur_v,
                                                 input logic inc,
                                                 input logic dec,
                                                 input logic [1:0] mag);
      logic signed [3:0] delta;
      logic signed [3:0] sum;
      delta = 4'sd0;
      if (inc && !dec)
         delta = $signed({2'b00, mag});
      else if (dec && !inc)
         delta = -$signed({2'b00, mag});
      sum = 4'(cur_v) + delta;
      if (sum > LIM)
         sum = LIM;
      else if (sum < -LIM)
         sum = -LIM;
      return sum[2:0];
   endfunction

   // Outputs are decoded from the state being left, so each output change
   // lands one edge after the state change that causes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pulse_cnt  <= 4'd0;
         prev       <= 5'd0;
         dx         <= 3'sd0;
         dy         <= 3'sd0;
         update     <= 1'b0;
         en0        <= 1'b0;
         en1        <= 1'b0;
         turn       <= 1'b0;
         move_count <= 8'd0;
      end else begin
         // History always tracks, so buttons held through a move stay quiet.
         prev <= cur;
         case (state)
            IDLE: begin
               en0    <= 1'b0;
               en1    <= 1'b0;
               update <= 1'b0;
               dx     <= sat_add(dx, press[2], press[1], step);
               dy     <= sat_add(dy, press[4], press[3], step);
               if (press[0] && (dx != 3'sd0 || dy != 3'sd0))
                  state <= SETUP;
            end
            SETUP: begin
               en0       <= ~turn;
               en1       <= turn;
               update    <= 1'b0;
               pulse_cnt <= 4'(PULSE_LEN - 1);
               state     <= PULSE;
            end
            PULSE: begin
               update <= 1'b1;
               if (pulse_cnt == 4'd0)
                  state <= HOLD;
               else
                  pulse_cnt <= pulse_cnt - 4'd1;
            end
            HOLD: begin
               update     <= 1'b0;
               turn       <= ~turn;
               dx         <= 3'sd0;
               dy         <= 3'sd0;
               move_count <= move_count + 8'd1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: table of button vectors with optional
// commits, a per-cycle expected-strobe queue during commits, and hand
// sequences for go-with-zero, async reset mid-pulse and counter wrap.
module tb_move_sequencer;

   localparam int PL = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up, btn_down, btn_right, btn_left, btn_go;
   logic [1:0] step_sel;
   logic [2:0] xMove, yMove;
   logic       update, en0, en1, turn;
   logic [7:0] move_count;

   int         checks = 0;
   int         errors = 0;
   logic       exp_turn;
   logic [7:0] exp_count;

   typedef struct {
      logic       up, down, right, left;
      logic [1:0] step;
      logic [2:0] ex, ey;
      logic       go, noise;
   } vec_t;

   typedef struct {
      logic en0, en1, upd;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];

   move_sequencer #(.PULSE_LEN(PL), .MAX_STEP(3)) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down),
      .btn_right(btn_right), .btn_left(btn_left),
      .btn_go(btn_go), .step_sel(step_sel),
      .xMove(xMove), .yMove(yMove), .update(update),
      .en0(en0), .en1(en1), .turn(turn), .move_count(move_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      checks++;
      assert (!(en0 && en1))
      else begin
         errors++;
         $display("FAIL en_exclusive: en0=%0b en1=%0b at %0t", en0, en1, $time);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic u, input logic d, input logic r, input logic l,
                        input logic [1:0] s, input logic [2:0] ex, input logic [2:0] ey);
      btn_up = u; btn_down = d; btn_right = r; btn_left = l; step_sel = s;
      tick();
      btn_up = 0; btn_down = 0; btn_right = 0; btn_left = 0;
      tick();
      check("press_x", xMove, ex);
      check("press_y", yMove, ey);
   endtask

   task automatic commit(input logic [2:0] ex, input logic [2:0] ey, input bit noise);
      int   rises;
      logic prev_upd;
      logic p;
      exp_t e;
      rises = 0;
      p = exp_turn;
      btn_go = 1;
      tick();
      check("setup_en0", en0, 0);
      check("setup_en1", en1, 0);
      check("setup_upd", update, 0);
      prev_upd = update;
      for (int k = 1; k <= PL + 3; k++) begin
         if (noise) begin
            btn_up = ((k - 1) < PL) && ((k - 1) % 2 == 0);
            btn_go = ((k - 1) >= 1) && (((k - 1) % 2 == 1) || ((k - 1) >= PL));
         end else begin
            btn_go = 0;
         end
         e.en0 = (p == 1'b0) && (k >= 1) && (k <= PL + 2);
         e.en1 = (p == 1'b1) && (k >= 1) && (k <= PL + 2);
         e.upd = (k >= 2) && (k <= PL + 1);
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         check("seq_en0", en0, e.en0);
         check("seq_en1", en1, e.en1);
         check("seq_update", update, e.upd);
         if (update && !prev_upd) rises++;
         prev_upd = update;
         if (k <= PL + 1) begin
            check("held_x", xMove, ex);
            check("held_y", yMove, ey);
         end
      end
      check("update_rises", rises, 1);
      exp_turn  = ~exp_turn;
      exp_count = exp_count + 8'd1;
      check("turn_after", turn, exp_turn);
      check("count_after", move_count, exp_count);
      check("x_cleared", xMove, 0);
      check("y_cleared", yMove, 0);
      if (noise) begin
         repeat (4) begin
            tick();
            check("held_go_quiet", {en0, en1, update}, 0);
         end
         check("held_go_count", move_count, exp_count);
         btn_go = 0;
         btn_up = 0;
         tick();
      end
   endtask

   initial begin
      vecs[0]  = '{0, 0, 1, 0, 2'd1, 3'd1, 3'd0, 0, 0};
      vecs[1]  = '{0, 0, 1, 0, 2'd1, 3'd2, 3'd0, 0, 0};
      vecs[2]  = '{1, 0, 0, 0, 2'd1, 3'd2, 3'd1, 1, 0};
      vecs[3]  = '{0, 0, 0, 1, 2'd3, 3'd5, 3'd0, 0, 0};
      vecs[4]  = '{0, 0, 0, 1, 2'd3, 3'd5, 3'd0, 1, 0};
      vecs[5]  = '{1, 0, 1, 0, 2'd2, 3'd2, 3'd2, 0, 0};
      vecs[6]  = '{0, 0, 1, 0, 2'd2, 3'd3, 3'd2, 0, 0};
      vecs[7]  = '{0, 1, 0, 0, 2'd3, 3'd3, 3'd7, 0, 0};
      vecs[8]  = '{0, 0, 0, 1, 2'd0, 3'd2, 3'd7, 1, 1};
      vecs[9]  = '{0, 0, 1, 1, 2'd1, 3'd0, 3'd0, 0, 0};
      vecs[10] = '{1, 1, 0, 0, 2'd3, 3'd0, 3'd0, 0, 0};

      rst = 1;
      btn_up = 0; btn_down = 0; btn_right = 0; btn_left = 0; btn_go = 0;
      step_sel = 2'd1;
      exp_turn = 0;
      exp_count = 8'd0;
      repeat (3) tick();
      check("rst_x", xMove, 0);
      check("rst_y", yMove, 0);
      check("rst_upd", update, 0);
      check("rst_en", {en0, en1}, 0);
      check("rst_turn", turn, 0);
      check("rst_count", move_count, 0);
      rst = 0;
      tick();

      for (int i = 0; i < 11; i++) begin
         press(vecs[i].up, vecs[i].down, vecs[i].right, vecs[i].left,
               vecs[i].step, vecs[i].ex, vecs[i].ey);
         if (vecs[i].go) commit(vecs[i].ex, vecs[i].ey, vecs[i].noise);
      end

      // go with nothing pending is ignored
      btn_go = 1;
      tick();
      btn_go = 0;
      repeat (5) begin
         tick();
         check("zero_go_quiet", {en0, en1, update}, 0);
      end
      check("zero_go_count", move_count, exp_count);
      check("zero_go_turn", turn, exp_turn);

      // async reset in the middle of the pulse
      press(0, 0, 1, 0, 2'd1, 3'd1, 3'd0);
      btn_go = 1;
      tick();
      btn_go = 0;
      tick();
      tick();
      check("pre_rst_upd", update, 1);
      check("pre_rst_en1", en1, 1);
      #2 rst = 1;
      #1;
      check("arst_upd", update, 0);
      check("arst_en", {en0, en1}, 0);
      check("arst_turn", turn, 0);
      check("arst_count", move_count, 0);
      check("arst_x", xMove, 0);
      @(negedge clk);
      rst = 0;
      exp_turn = 0;
      exp_count = 8'd0;
      repeat (3) begin
         tick();
         check("post_rst_quiet", {en0, en1, update}, 0);
      end

      // counter wrap
      for (int i = 0; i < 256; i++) begin
         press(0, 0, 1, 0, 2'd1, 3'd1, 3'd0);
         commit(3'd1, 3'd0, 0);
      end
      check("wrap_count", move_count, 0);
      check("wrap_turn", turn, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
